mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit and its sequencer for the pipelined MIPS core, instantiated in the E stage.
- Owns the HI/LO registers and executes mult/multu/div/divu with fixed latencies.
- Services mthi/mtlo/mfhi/mflo.
- Generates the stall request that the hazard unit uses to freeze D while an MD instruction cannot proceed.

---
 rtl/mdu_ctrl.sv | 116 +++++++++++
 tb/tb_mdu_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs mult/multu/div/divu
// with fixed busy latencies, services mthi/mtlo/mfhi/mflo and raises the D-stage stall.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] wdata,
    input  logic        d_md_use,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        stall_req
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  count_p0;
    logic [1:0]  op_p0;
    logic [31:0] a_p0;
    logic [31:0] b_p0;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        idle;
    logic        done;
    logic        div_zero;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    function automatic logic [63:0] mul_full(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        ae = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        be = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ae * be;
    endfunction

    // Returns {remainder, quotient}. The INT_MIN / -1 case is pinned explicitly
    // because a native signed divide overflows there.
    function automatic logic [63:0] div_full(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign idle       = (count_p0 == 4'd0);
    assign done       = (count_p0 == 4'd1);
    assign div_zero   = (b_p0 == 32'd0);
    assign prod       = mul_full(~op_p0[0], a_p0, b_p0);
    assign {rem, quo} = div_full(~op_p0[0], a_p0, b_p0);

    assign busy      = ~idle;
    assign rdata     = hilo_sel ? hi : lo;
    assign stall_req = d_md_use & (start | busy);

    // Issue stage: latch operands on start; completion edge writes HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            count_p0 <= 4'd0;
            op_p0    <= 2'd0;
            a_p0     <= 32'd0;
            b_p0     <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (idle) begin
            if (start) begin
                op_p0    <= op;
                a_p0     <= rs_val;
                b_p0     <= rt_val;
                count_p0 <= op[1] ? DIV_LOAD : MULT_LOAD;
            end else if (hilo_we) begin
                if (hilo_sel) hi <= wdata;
                else          lo <= wdata;
            end
        end else begin
            count_p0 <= count_p0 - 4'd1;
            if (done) begin
                if (!op_p0[1]) begin
                    {hi, lo} <= prod;
                end else if (!div_zero) begin
                    hi <= rem;
                    lo <= quo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of arithmetic vectors plus hand-written
// sequences for stall, collision, mid-busy and reset-abort behaviour.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] wdata;
    logic        d_md_use;
    logic        busy;
    logic [31:0] rdata;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
        .d_md_use(d_md_use), .busy(busy), .rdata(rdata), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic sel, output logic [31:0] val);
        hilo_sel = sel;
        #1;
        val = rdata;
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] data);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        wdata    = data;
        tick();
        hilo_we  = 1'b0;
    endtask

    // Starts an op, scrambles operands after the start edge, returns busy length.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        op     = 2'(3 - o);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] v;
        int          n;

        vecs[0] = '{"mult_neg",    2'd0, 32'd3,        32'hFFFF_FFFE, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{"multu_max2",  2'd1, 32'hFFFF_FFFF, 32'd2,        32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{"div_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2,        32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"divu_zero",   2'd3, 32'd99,       32'd0,         32'hAAAA_5555, 32'h1234_5678, 32'hAAAA_5555, 32'h1234_5678, 10};
        vecs[4] = '{"div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5] = '{"divu_100_7",  2'd3, 32'd100,      32'd7,         32'h0, 32'h0, 32'd2,         32'd14,        10};
        vecs[6] = '{"div_7_m2",    2'd2, 32'd7,        32'hFFFF_FFFE, 32'h0, 32'h0, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[7] = '{"mult_min2",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[8] = '{"multu_ff_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[9] = '{"div_zero",    2'd2, 32'd5,        32'd0,         32'h0BAD_F00D, 32'hFEED_BEEF, 32'h0BAD_F00D, 32'hFEED_BEEF, 10};

        reset = 1'b1; start = 1'b0; op = 2'd0; rs_val = 32'd0; rt_val = 32'd0;
        hilo_we = 1'b0; hilo_sel = 1'b0; wdata = 32'd0; d_md_use = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("reset_busy", {31'd0, busy}, 32'd0);
        read_reg(1'b0, v); check("reset_lo", v, 32'd0);
        read_reg(1'b1, v); check("reset_hi", v, 32'd0);
        d_md_use = 1'b1; #1;
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        d_md_use = 1'b0;

        for (int i = 0; i < 10; i++) begin
            write_reg(1'b1, vecs[i].pre_hi);
            write_reg(1'b0, vecs[i].pre_lo);
            read_reg(1'b0, v);
            check({vecs[i].name, "_mtlo"}, v, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cycles));
            read_reg(1'b1, v); check({vecs[i].name, "_hi"}, v, vecs[i].exp_hi);
            read_reg(1'b0, v); check({vecs[i].name, "_lo"}, v, vecs[i].exp_lo);
        end

        // Stall request: start cycle plus every busy cycle, then released
        d_md_use = 1'b1;
        start = 1'b1; op = 2'd2; rs_val = 32'd9; rt_val = 32'd3;
        #1;
        check("stall_start", {31'd0, stall_req}, 32'd1);
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            check($sformatf("stall_busy%0d", n), {31'd0, stall_req}, 32'd1);
            n++;
            tick();
        end
        check("stall_cycles", 32'(n), 32'd10);
        check("stall_release", {31'd0, stall_req}, 32'd0);
        read_reg(1'b0, v); check("stall_div_lo", v, 32'd3);

        d_md_use = 1'b0;
        start = 1'b1; op = 2'd0; rs_val = 32'd1; rt_val = 32'd1;
        tick();
        start = 1'b0;
        check("nouse_busy", {31'd0, busy}, 32'd1);
        check("nouse_stall", {31'd0, stall_req}, 32'd0);
        n = 0;
        while (busy && n < 40) begin n++; tick(); end
        check("nouse_cycles", 32'(n), 32'd5);

        // start and hilo_we in the same idle cycle: write dropped (div-by-zero keeps HI observable)
        write_reg(1'b1, 32'h5A5A_0001);
        write_reg(1'b0, 32'h5A5A_0002);
        start = 1'b1; op = 2'd3; rs_val = 32'd5; rt_val = 32'd0;
        hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; hilo_we = 1'b0;
        n = 0;
        while (busy && n < 40) begin n++; tick(); end
        check("collide_cycles", 32'(n), 32'd10);
        read_reg(1'b1, v); check("collide_hi", v, 32'h5A5A_0001);
        read_reg(1'b0, v); check("collide_lo", v, 32'h5A5A_0002);

        // start and hilo_we pulsed mid-busy must not disturb the in-flight op
        start = 1'b1; op = 2'd3; rs_val = 32'd7; rt_val = 32'd0;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 3) begin
                start = 1'b1; op = 2'd1; rs_val = 32'd2; rt_val = 32'd3;
                hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hCAFE_F00D;
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            tick();
        end
        start = 1'b0; hilo_we = 1'b0;
        check("midbusy_cycles", 32'(n), 32'd10);
        read_reg(1'b1, v); check("midbusy_hi", v, 32'h5A5A_0001);
        read_reg(1'b0, v); check("midbusy_lo", v, 32'h5A5A_0002);

        // Reset in busy cycle 3 of a div aborts it with no later HI/LO update
        start = 1'b1; op = 2'd2; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        read_reg(1'b1, v); check("abort_hi", v, 32'd0);
        read_reg(1'b0, v); check("abort_lo", v, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_busy_late", {31'd0, busy}, 32'd0);
        read_reg(1'b1, v); check("abort_hi_late", v, 32'd0);
        read_reg(1'b0, v); check("abort_lo_late", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
